// File: rtl/netlist_pkg.sv
// Shared types and constants for the netlist_top 8-bit processor: opcodes,
// instruction layout and the built-in default program.
package netlist_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_JMP  = 4'h8,
    OP_BEQZ = 4'h9,
    OP_BNEZ = 4'hA,
    OP_OUT  = 4'hB,
    OP_MUL  = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e     op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
  } instr_t;

  localparam int unsigned DEFAULT_LEN = 9;

  // Counts r0 from 0 to 5 through the output port, then halts at address 8.
  localparam logic [INSTR_W-1:0] DEFAULT_PROG [DEFAULT_LEN] = '{
    16'h1000,  // LDI  r0,0
    16'h1401,  // LDI  r1,1
    16'h1805,  // LDI  r2,5
    16'hB000,  // OUT  r0
    16'h2100,  // ADD  r0,r1
    16'h3900,  // SUB  r2,r1
    16'hA803,  // BNEZ r2,3
    16'hB000,  // OUT  r0
    16'hF000   // HALT
  };

  function automatic logic [INSTR_W-1:0] default_word(logic [7:0] addr);
    logic [INSTR_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < DEFAULT_LEN; i++) begin
      if (addr == 8'(i)) w = DEFAULT_PROG[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/netlist_if.sv
// Observation bundle of netlist_top: program counter, output port and halt flag.
interface netlist_if;
  import netlist_pkg::*;

  logic [DATA_W-1:0] Pc;
  logic [DATA_W-1:0] OutData;
  logic              OutValid;
  logic              Halted;

  modport master (output Pc, output OutData, output OutValid, output Halted);
  modport slave  (input  Pc, input  OutData, input  OutValid, input  Halted);
endinterface

// File: rtl/netlist_alu.sv
// Combinational 8-bit ALU; results wrap modulo 2^8.
// MUL exists only when NETLIST_MUL_EN is defined.
module netlist_alu
  import netlist_pkg::*;
(
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = a_i;
    case (op_i)
      OP_LDI:  res_o = imm_i;
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_ADDI: res_o = a_i + imm_i;
`ifdef NETLIST_MUL_EN
      OP_MUL:  res_o = a_i * b_i;
`endif
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/netlist_top.sv
// Single-cycle 8-bit processor: PC, 16-bit ROM, 4x8 register file, ALU, output port.
// Build option: NETLIST_MUL_EN enables opcode C (MUL); otherwise C is a NOP.
module netlist_top
  import netlist_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 256,
  parameter string       PROG_FILE = "",
  // Image of PROG_FILE rendered by the build flow; word n at bits [16n +: 16].
  parameter logic [ROM_DEPTH*INSTR_W-1:0] PROG_IMAGE = '0
) (
  input  logic Clock,
  input  logic Reset,
  netlist_if.master obs
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam bit USE_DEFAULT = (PROG_FILE == "");

  state_e            state_q;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  int unsigned        rom_idx;
  logic [INSTR_W-1:0] rom_word;
  instr_t             ins;
  logic [DATA_W-1:0]  rd_val, rs_val, alu_res;
  logic               wr_en, out_en, halt_en;

  always_comb begin
    rom_idx  = 32'(pc_q) % ROM_DEPTH;
    rom_word = USE_DEFAULT ? default_word(8'(rom_idx))
                           : PROG_IMAGE[rom_idx*INSTR_W +: INSTR_W];
    ins      = instr_t'(rom_word);
    rd_val   = regs_q[ins.rd];
    rs_val   = regs_q[ins.rs];
  end

  netlist_alu u_alu (
    .op_i  (ins.op),
    .a_i   (rd_val),
    .b_i   (rs_val),
    .imm_i (ins.imm),
    .res_o (alu_res)
  );

  always_comb begin
    pc_d    = pc_q + 8'd1;
    wr_en   = 1'b0;
    out_en  = 1'b0;
    halt_en = 1'b0;
    case (ins.op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: wr_en = 1'b1;
`ifdef NETLIST_MUL_EN
      OP_MUL:  wr_en = 1'b1;
`endif
      OP_JMP:  pc_d = ins.imm;
      OP_BEQZ: if (rd_val == '0) pc_d = ins.imm;
      OP_BNEZ: if (rd_val != '0) pc_d = ins.imm;
      OP_OUT:  out_en = 1'b1;
      OP_HALT: begin
        pc_d    = pc_q;
        halt_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Once halted, only OutValid keeps updating (to clear a pending pulse).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      regs_q      <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      pc_q        <= pc_d;
      out_valid_q <= out_en;
      if (wr_en)   regs_q[ins.rd] <= alu_res;
      if (out_en)  out_data_q     <= rd_val;
      if (halt_en) state_q        <= ST_HALT;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign obs.Pc       = pc_q;
  assign obs.OutData  = out_data_q;
  assign obs.OutValid = out_valid_q;
  assign obs.Halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_netlist_top.sv
// Scoreboard bench for netlist_top: four instances (default, ALU/wrap, branch, MUL programs).
module tb_netlist_top;

  localparam int unsigned W = 256 * 16;

  function automatic logic [W-1:0] at(int unsigned a, logic [15:0] d);
    return W'(d) << (16 * a);
  endfunction

  // Wrap-around, logic ops and back-to-back OUT; outputs 00 FF 30 3C C3 FF.
  localparam logic [W-1:0] IMG_ALU =
      at(0, 16'h10FF) | at(1, 16'h7001) | at(2, 16'hB000) | at(3, 16'h1400)
    | at(4, 16'h1801) | at(5, 16'h3600) | at(6, 16'hB400) | at(7, 16'h1CF0)
    | at(8, 16'h183C) | at(9, 16'h4E00) | at(10, 16'hBC00) | at(11, 16'h5E00)
    | at(12, 16'hBC00) | at(13, 16'h6D00) | at(14, 16'hBC00) | at(15, 16'hB400)
    | at(16, 16'hF000);

  // Taken/not-taken branches and JMP 0xFF wrapping to 0; words 2,3 must never run.
  localparam logic [W-1:0] IMG_BR =
      at(0, 16'h1000) | at(1, 16'h9010) | at(2, 16'h1CEE) | at(3, 16'hBC00)
    | at(16, 16'h1403) | at(17, 16'h9430) | at(18, 16'hB400) | at(19, 16'hA420)
    | at(32, 16'hA030) | at(33, 16'h80FF);

  localparam logic [W-1:0] IMG_MUL =
      at(0, 16'h1014) | at(1, 16'h140D) | at(2, 16'hC100) | at(3, 16'hB000)
    | at(4, 16'hF000);

  logic Clock = 1'b0;
  logic rst_def = 1'b1, rst_alu = 1'b1, rst_br = 1'b1, rst_mul = 1'b1;

  always #5 Clock = ~Clock;

  netlist_if if_def ();
  netlist_if if_alu ();
  netlist_if if_br ();
  netlist_if if_mul ();

  netlist_top #(.ROM_DEPTH(256)) u_def (.Clock(Clock), .Reset(rst_def), .obs(if_def));
  netlist_top #(.ROM_DEPTH(256), .PROG_FILE("alu.hex"), .PROG_IMAGE(IMG_ALU))
    u_alu (.Clock(Clock), .Reset(rst_alu), .obs(if_alu));
  netlist_top #(.ROM_DEPTH(256), .PROG_FILE("br.hex"), .PROG_IMAGE(IMG_BR))
    u_br (.Clock(Clock), .Reset(rst_br), .obs(if_br));
  netlist_top #(.ROM_DEPTH(256), .PROG_FILE("mul.hex"), .PROG_IMAGE(IMG_MUL))
    u_mul (.Clock(Clock), .Reset(rst_mul), .obs(if_mul));

  typedef struct {
    string       name;
    int unsigned act;
    int unsigned exp;
  } chk_t;

  chk_t        chk_q [$];
  logic [7:0]  exp_q [4][$];
  int unsigned seen [4] = '{0, 0, 0, 0};
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       nm [4] = '{"def", "alu", "br", "mul"};

  logic       ov [4];
  logic [7:0] od [4];
  always_comb begin
    ov[0] = if_def.OutValid; od[0] = if_def.OutData;
    ov[1] = if_alu.OutValid; od[1] = if_alu.OutData;
    ov[2] = if_br.OutValid;  od[2] = if_br.OutData;
    ov[3] = if_mul.OutValid; od[3] = if_mul.OutData;
  end

  function automatic void chk_eq(string name, int unsigned act, int unsigned exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  // Monitor: drains queued direct checks and scores every OUT pulse.
  always @(negedge Clock) begin : monitor
    chk_t       c;
    logic [7:0] e;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act != c.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", c.name, c.act, c.exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ov[i] === 1'b1) begin
        n_cmp++;
        seen[i]++;
        if (exp_q[i].size() == 0) begin
          n_bad++;
          $display("FAIL %s_out: got OUT 0x%02h, required no OUT", nm[i], od[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (od[i] !== e) begin
            n_bad++;
            $display("FAIL %s_out: got 0x%02h, required 0x%02h", nm[i], od[i], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin : stim
    logic [7:0] br_trace [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h20, 8'h21, 8'hFF, 8'h00, 8'h01, 8'h10};
    logic [7:0] alu_exp [6] = '{8'h00, 8'hFF, 8'h30, 8'h3C, 8'hC3, 8'hFF};

    #2;
    chk_eq("rst_pc",       if_def.Pc,       0);
    chk_eq("rst_outdata",  if_def.OutData,  0);
    chk_eq("rst_outvalid", if_def.OutValid, 0);
    chk_eq("rst_halted",   if_def.Halted,   0);

    // ALU/wrap and MUL programs run side by side.
    foreach (alu_exp[i]) exp_q[1].push_back(alu_exp[i]);
`ifdef NETLIST_MUL_EN
    exp_q[3].push_back(8'h04);
`else
    exp_q[3].push_back(8'h14);
`endif
    rst_alu = 1'b0;
    rst_mul = 1'b0;
    repeat (30) tick();
    chk_eq("alu_halted", if_alu.Halted, 1);
    chk_eq("alu_pc",     if_alu.Pc,     16);
    chk_eq("mul_halted", if_mul.Halted, 1);
    chk_eq("mul_pc",     if_mul.Pc,     4);

    // Branch program: cycle-by-cycle PC trace, then held in reset before it loops.
    exp_q[2].push_back(8'h03);
    rst_br = 1'b0;
    chk_eq("br_pc0", if_br.Pc, br_trace[0]);
    for (int k = 1; k < 12; k++) begin
      tick();
      chk_eq($sformatf("br_pc%0d", k), if_br.Pc, br_trace[k]);
    end
    rst_br = 1'b1;

    // Default program, interrupted by an asynchronous reset while r0 = 3.
    exp_q[0].push_back(8'h00);
    exp_q[0].push_back(8'h01);
    exp_q[0].push_back(8'h02);
    rst_def = 1'b0;
    for (int k = 0; k < 200 && seen[0] < 3; k++) tick();
    chk_eq("def_first3_seen", seen[0], 3);
    #2;
    chk_eq("def_pre_rst_outdata", if_def.OutData, 2);
    rst_def = 1'b1;
    #1;
    chk_eq("midrst_pc",       if_def.Pc,       0);
    chk_eq("midrst_outdata",  if_def.OutData,  0);
    chk_eq("midrst_outvalid", if_def.OutValid, 0);
    chk_eq("midrst_halted",   if_def.Halted,   0);
    #9;
    for (int v = 0; v < 6; v++) exp_q[0].push_back(8'(v));
    rst_def = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 30 || c == 50) begin
        chk_eq($sformatf("def_halted_c%0d", c), if_def.Halted, 1);
        chk_eq($sformatf("def_pc_c%0d", c),     if_def.Pc,     8);
      end
    end
    chk_eq("def_out_count", seen[0], 9);
    for (int i = 0; i < 4; i++)
      chk_eq($sformatf("%s_pending", nm[i]), exp_q[i].size(), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
